// File: rtl/spi_regif_pkg.sv
// Shared constants, FSM state type and write-decode helpers for the SPI register front end.
// Latency: n/a (package only).
// Backpressure: n/a; the SPI host paces every transfer.
package spi_regif_pkg;

    // Frame geometry: one command byte followed by one data byte.
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // Bit-counter values seen on the rising edge that closes each byte.
    localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(FRAME_BITS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME_END = CNT_W'(FRAME_BITS - 1);
    // Counter value while the first read bit is already on miso; the falling
    // edge at this count must not shift it away.
    localparam logic [CNT_W-1:0] CNT_DATA_HOLD = CNT_W'(FRAME_BITS / 2);

    // Register address map.
    localparam logic [3:0] ADDR_CTRL    = 4'd0;
    localparam logic [3:0] ADDR_CFG0    = 4'd1;
    localparam logic [3:0] ADDR_CFG1    = 4'd2;
    localparam logic [3:0] ADDR_CFG2    = 4'd3;
    localparam logic [3:0] ADDR_WDOGDIV = 4'd4;
    localparam logic [3:0] ADDR_HWCFG   = 4'd5;
    localparam logic [3:0] ADDR_WDKICK  = 4'd6;

    // Bit positions inside the write-strobe vector.
    localparam int STRB_W       = 6;
    localparam int STRB_CTRL    = 0;
    localparam int STRB_CFG0    = 1;
    localparam int STRB_CFG1    = 2;
    localparam int STRB_CFG2    = 3;
    localparam int STRB_WDOGDIV = 4;
    localparam int STRB_WDKICK  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    // One-hot load strobe for a completed write; unmapped addresses give none.
    function automatic logic [STRB_W-1:0] wr_strobe(input logic [3:0] addr);
        logic [STRB_W-1:0] s;
        s = '0;
        case (addr)
            ADDR_CTRL:    s[STRB_CTRL]    = 1'b1;
            ADDR_CFG0:    s[STRB_CFG0]    = 1'b1;
            ADDR_CFG1:    s[STRB_CFG1]    = 1'b1;
            ADDR_CFG2:    s[STRB_CFG2]    = 1'b1;
            ADDR_WDOGDIV: s[STRB_WDOGDIV] = 1'b1;
            ADDR_WDKICK:  s[STRB_WDKICK]  = 1'b1;
            default:      s = '0;
        endcase
        return s;
    endfunction

    // Only real register writes carry data; the watchdog kick discards its byte.
    function automatic logic wr_updates_data(input logic [3:0] addr);
        return (addr <= ADDR_WDOGDIV);
    endfunction

endpackage

// File: rtl/spi_regif_sync.sv
// Metastability synchronizer plus edge register for one asynchronous SPI pin.
// Latency: a pin change shows on level/rise/fall SYNC_STAGES+1 clocks later.
// Backpressure: none; free-running sampler.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Fewer than two stages gives no real metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;
    logic              sync_out;

    assign sync_out = sync_q[STAGES-1];

    // Synchronizer chain followed by one edge register; level and edge pulses
    // leave together so the consumer sees them on the same clock.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], pin_i};
            level_q <= sync_out;
            rise_q  <= sync_out & ~level_q;
            fall_q  <= ~sync_out & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave: 16-bit frames become register load strobes / readback bytes.
// Latency: write strobe 1 clk after the 16th detected sclk rise; pins detected SYNC_STAGES+1 clks late.
// Backpressure: none; the host paces frames and the control block must take every strobe.
module spi_regif
    import spi_regif_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ssn,
    output logic       miso,
    output logic       misoen,
    input  logic [7:0] controlrdata,
    input  logic [7:0] hwconfig,
    output logic [7:0] wrtdata,
    output logic       ctrlld,
    output logic       cfgld0,
    output logic       cfgld1,
    output logic       cfgld2,
    output logic       wdogdivld,
    output logic       wdreset
);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;
    logic sclk_lvl_unused;
    logic mosi_lvl;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic ssn_lvl;
    logic ssn_fall;
    logic ssn_rise_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (sclk),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (mosi),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    // The ssn synchronizer resets low, so a select that is already low when
    // reset drops never produces a falling edge and cannot start a frame.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ssn (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (ssn),
        .level_o (ssn_lvl),
        .rise_o  (ssn_rise_unused),
        .fall_o  (ssn_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [6:0]        rx_q;       // bits received so far in the current byte
    logic [6:0]        rx_d;
    logic [6:0]        tx_q;       // read bits still to be shifted out
    logic [6:0]        tx_d;
    logic              miso_q;
    logic              rd_q;       // current frame is a read
    logic [3:0]        addr_q;
    logic [7:0]        wrtdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              ssn_seen_high_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0]        cmd_addr;
    logic              cmd_rd;
    logic [7:0]        wr_byte;
    logic [7:0]        rd_byte;
    logic [STRB_W-1:0] wr_strb;

    // The byte-closing rise has its last bit on mosi_lvl, not yet in rx_q.
    assign cmd_addr = {rx_q[2:0], mosi_lvl};
    assign cmd_rd   = rx_q[6];
    assign wr_byte  = {rx_q, mosi_lvl};
    assign wr_strb  = wr_strobe(addr_q);

    // Shift and count next-values shared by the command and data phases.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        rx_d  = {rx_q[5:0], mosi_lvl};
        tx_d  = {tx_q[5:0], 1'b0};
    end

    // Read mux addressed by the command byte as it completes.
    always_comb begin
        rd_byte = 8'h00;
        case (cmd_addr)
            ADDR_CTRL:  rd_byte = controlrdata;
            ADDR_HWCFG: rd_byte = hwconfig;
            default:    rd_byte = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered miso, strobes and write data
    // ------------------------------------------------------------------
    // A high select always wins, so a deselect on the same clock as the
    // 16th rise aborts the frame without a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wrtdata_q <= 8'h00;
            strb_q    <= '0;
        end else begin
            strb_q <= '0;
            if (ssn_lvl) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        miso_q <= 1'b0;
                        if (ssn_fall) begin
                            state_q <= ST_CMD;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CMD: begin
                        miso_q <= 1'b0;
                        if (sclk_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_d;
                            if (cnt_q == CNT_CMD_LAST) begin
                                // Single snapshot of the read byte; bit 7 goes
                                // straight onto miso, the rest waits in tx_q.
                                state_q <= ST_DATA;
                                rd_q    <= cmd_rd;
                                addr_q  <= cmd_addr;
                                tx_q    <= cmd_rd ? rd_byte[6:0] : 7'h00;
                                miso_q  <= cmd_rd & rd_byte[7];
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_q  <= rx_d;
                            cnt_q <= cnt_d;
                            if (cnt_q == CNT_FRAME_END) begin
                                state_q <= ST_DONE;
                                miso_q  <= 1'b0;
                                if (!rd_q) begin
                                    strb_q <= wr_strb;
                                    if (wr_updates_data(addr_q)) begin
                                        wrtdata_q <= wr_byte;
                                    end
                                end
                            end
                        end else if (sclk_fall && (cnt_q != CNT_DATA_HOLD)) begin
                            miso_q <= tx_q[6];
                            tx_q   <= tx_d;
                        end
                    end
                    ST_DONE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output enable needs a high select since reset, so a select held low
    // through reset keeps the buffer off until the host toggles it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ssn_seen_high_q <= 1'b0;
        end else if (ssn_lvl) begin
            ssn_seen_high_q <= 1'b1;
        end
    end

    assign misoen    = ~ssn_lvl & ssn_seen_high_q;
    assign miso      = miso_q;
    assign wrtdata   = wrtdata_q;
    assign ctrlld    = strb_q[STRB_CTRL];
    assign cfgld0    = strb_q[STRB_CFG0];
    assign cfgld1    = strb_q[STRB_CFG1];
    assign cfgld2    = strb_q[STRB_CFG2];
    assign wdogdivld = strb_q[STRB_WDOGDIV];
    assign wdreset   = strb_q[STRB_WDKICK];

endmodule

// File: tb/tb_spi_regif.sv
// Scoreboard bench for spi_regif: directed SPI frames, expected events queued at issue.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_regif;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       ssn;
    logic       miso;
    logic       misoen;
    logic [7:0] controlrdata;
    logic [7:0] hwconfig;
    logic [7:0] wrtdata;
    logic       ctrlld, cfgld0, cfgld1, cfgld2, wdogdivld, wdreset;

    spi_regif #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .mosi         (mosi),
        .ssn          (ssn),
        .miso         (miso),
        .misoen       (misoen),
        .controlrdata (controlrdata),
        .hwconfig     (hwconfig),
        .wrtdata      (wrtdata),
        .ctrlld       (ctrlld),
        .cfgld0       (cfgld0),
        .cfgld1       (cfgld1),
        .cfgld2       (cfgld2),
        .wdogdivld    (wdogdivld),
        .wdreset      (wdreset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] strb;   // {wdreset, wdogdivld, cfgld2, cfgld1, cfgld0, ctrlld}
        logic [7:0] data;
    } strb_ev_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    strb_ev_t    exp_strb_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] obs_rd_q[$];
    logic [7:0]  exp_wrtdata;

    logic [5:0] strb_obs;
    assign strb_obs = {wdreset, wdogdivld, cfgld2, cfgld1, cfgld0, ctrlld};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe cycle and every completed host frame is matched
    // against the next queued expectation.
    initial begin
        strb_ev_t    e;
        logic [15:0] got;
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (strb_obs != 6'b0) begin
                if (exp_strb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got strobes %b wrtdata 0x%h, expected no strobe",
                             strb_obs, wrtdata);
                end else begin
                    e = exp_strb_q.pop_front();
                    check("strobe_event", 32'({strb_obs, wrtdata}), 32'({e.strb, e.data}));
                end
            end
            if (obs_rd_q.size() > 0) begin
                got = obs_rd_q.pop_front();
                if (exp_rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got miso 0x%h, expected no frame", got);
                end else begin
                    exp = exp_rd_q.pop_front();
                    check("miso_frame", 32'(got), 32'(exp));
                end
            end
        end
    end

    // Host side of one frame; 6-clock sclk half periods. Optionally pulses
    // reset or changes hwconfig right after a given rising edge (1-based).
    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                             input int rst_bit, input int chg_bit, input logic [7:0] chg_val);
        logic [15:0] frame;
        logic [15:0] got;
        frame = {cmd, dat};
        got   = 16'h0000;
        ssn   = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[15-i];
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            got[15-i] = miso;
            check("misoen_in_frame", 32'(misoen), 32'(rst_bit == 0 || i < rst_bit));
            if (rst_bit != 0 && i + 1 == rst_bit) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            if (chg_bit != 0 && i + 1 == chg_bit) hwconfig = chg_val;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        ssn  = 1'b1;
        mosi = 1'b0;
        if (nbits == 16 && rst_bit == 0) obs_rd_q.push_back(got);
        repeat (8) @(negedge clk);
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] dat,
                            input logic [5:0] strb, input logic upd);
        if (upd) exp_wrtdata = dat;
        if (strb != 6'b0) exp_strb_q.push_back({strb, exp_wrtdata});
        exp_rd_q.push_back(16'h0000);
        spi_frame(cmd, dat, 16, 0, 0, 8'h00);
        check("wrtdata_after_write", 32'(wrtdata), 32'(exp_wrtdata));
    endtask

    task automatic rd_frame(input logic [7:0] cmd, input logic [7:0] exp_byte,
                            input int chg_bit, input logic [7:0] chg_val);
        exp_rd_q.push_back({8'h00, exp_byte});
        spi_frame(cmd, 8'h00, 16, 0, chg_bit, chg_val);
        check("wrtdata_after_read", 32'(wrtdata), 32'(exp_wrtdata));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        sclk         = 1'b0;
        mosi         = 1'b0;
        ssn          = 1'b1;
        controlrdata = 8'h00;
        hwconfig     = 8'h00;
        exp_wrtdata  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_miso",    32'(miso),     0);
        check("reset_misoen",  32'(misoen),   0);
        check("reset_wrtdata", 32'(wrtdata),  0);
        check("reset_strobes", 32'(strb_obs), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_misoen", 32'(misoen), 0);

        // Address 1 write.
        wr_frame(8'h01, 8'h0B, 6'b000010, 1'b1);
        // Control readback.
        controlrdata = 8'hA5;
        rd_frame(8'h80, 8'hA5, 0, 8'h00);
        // hwconfig readback; input changes mid data byte, snapshot must hold.
        hwconfig = 8'h30;
        rd_frame(8'h85, 8'h30, 11, 8'hC7);
        // Command bits 6:4 are ignored: 0xF0 still reads address 0.
        controlrdata = 8'h3C;
        rd_frame(8'hF0, 8'h3C, 0, 8'h00);
        // Config and unmapped addresses read as zero.
        rd_frame(8'h81, 8'h00, 0, 8'h00);
        rd_frame(8'h89, 8'h00, 0, 8'h00);
        // Watchdog kick: pulse only, data byte discarded.
        wr_frame(8'h06, 8'hFF, 6'b100000, 1'b0);
        // Write to read-only hwconfig: nothing happens.
        wr_frame(8'h05, 8'h12, 6'b000000, 1'b0);
        // Aborted after 12 bits.
        spi_frame(8'h04, 8'h3C, 12, 0, 0, 8'h00);
        check("wrtdata_after_abort", 32'(wrtdata), 32'(exp_wrtdata));
        // Full frame to the same address.
        wr_frame(8'h04, 8'h3C, 6'b010000, 1'b1);
        // Address 3 with ignored command bits set, address 2, unmapped 15.
        wr_frame(8'h73, 8'h77, 6'b001000, 1'b1);
        wr_frame(8'h02, 8'h5E, 6'b000100, 1'b1);
        wr_frame(8'h0F, 8'hAA, 6'b000000, 1'b0);
        // Reset after 10 bits of a control write.
        exp_wrtdata = 8'h00;
        spi_frame(8'h00, 8'h55, 16, 10, 0, 8'h00);
        check("wrtdata_after_reset", 32'(wrtdata), 32'(exp_wrtdata));
        check("misoen_after_reset",  32'(misoen),  0);
        // Fresh select works again.
        wr_frame(8'h00, 8'h55, 6'b000001, 1'b1);

        repeat (10) @(negedge clk);
        check("pending_strobe_expectations", 32'(exp_strb_q.size()), 0);
        check("pending_frame_expectations",  32'(exp_rd_q.size()),   0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regif.md
# spi_regif

SPI slave register front end for the motor controller. It decodes 16-bit host frames into the one-clock load strobes and the `wrtdata` byte consumed by the control block. It also returns control-status and hardware-config bytes to the host over `miso`. It is the initiator side of the control block's register-write and readback interface and sits between the board SPI pins and the control block.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `mosi` and `ssn` (minimum 2).

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `mosi` in 1: SPI data in, MSB first.
- `ssn` in 1: SPI select, active low.
- `miso` out 1: SPI data out, MSB first.
- `misoen` out 1: `miso` output-buffer enable; high only while `ssn` is low (synchronized).
- `controlrdata` in 8: control/status readback byte from the control block.
- `hwconfig` in 8: hardware configuration byte from the control block.
- `wrtdata` out 8: write data byte for the control block; holds the last written value.
- `ctrlld`, `cfgld0`, `cfgld1`, `cfgld2`, `wdogdivld` out 1 each: one-clock register load strobes.
- `wdreset` out 1: one-clock watchdog kick pulse.

## Operation
- Frame is 16 bits while `ssn` is low.
  - Byte 0 is the command: bit 7 = R/W̄ (1 = read), bits 6:4 are ignored, bits 3:0 are the address.
  - Byte 1 is the data: write data from the host, or read data returned to the host.
- Address map:
  - 0: control. Write pulses `ctrlld`; read returns `controlrdata`.
  - 1, 2, 3: write pulses `cfgld0`, `cfgld1`, `cfgld2`; reads return 0x00.
  - 4: write pulses `wdogdivld`; read returns 0x00.
  - 5: read returns `hwconfig`; write is ignored.
  - 6: any write pulses `wdreset`; the data byte is ignored.
  - 7–15: writes are ignored; reads return 0x00.
- Ignored writes produce no strobe and leave `wrtdata` unchanged.
- FSM states:
  - IDLE → CMD on `ssn` falling.
  - CMD → DATA after the 8th `sclk` rising edge.
  - DATA → DONE after the 16th rising edge.
  - DONE → IDLE on `ssn` high.
  - In any state, `ssn` high forces IDLE.
- Bits beyond 16 are ignored while in DONE. `miso` is 0 in DONE.
- Write completion: `wrtdata` is updated and the decoded strobe is pulsed in the same cycle.
- Read: the address is latched at the 8th rising edge, and the read byte is sampled from its input exactly once. The snapshot does not change for the rest of the frame.
- Reset values:
  - `miso`, `misoen`, all strobes, `wdreset`: 0.
  - `wrtdata`: 0x00.
  - FSM: IDLE; bit counter: 0.

## Timing
- Inputs pass through `SYNC_STAGES` flops, then one edge-detect register. A pin edge is therefore detected `SYNC_STAGES`+1 clocks later (3 at default).
- `sclk` high and low times must each be at least 4 `clk` periods; the block does not detect violations.
- `mosi` is sampled on the detected `sclk` rising edge.
- `miso` changes only on detected `sclk` falling edges, with one exception: bit 7 of the read byte is loaded 1 clock after the 8th detected rising edge.
- During the command byte, and on write frames, `miso` = 0.
- Write strobe: asserted exactly 1 clock after the 16th detected rising edge, for 1 clock. At most one strobe per frame.
- Abort: `ssn` deassertion detected in the same cycle as, or before, the 16th rising edge. Result: no strobe, `wrtdata` unchanged, state IDLE.
- `misoen` follows the synchronized `ssn` with the same 3-clock delay.
- `reset` asserted mid-frame: outputs return to reset values the next clock. The block stays in IDLE until a fresh `ssn` falling edge; a select that is already low does not start a frame.
- Back-to-back frames: `ssn` must be high for at least 4 clocks between frames.

## Structure
- Shared package `spi_regif_pkg` holds:
  - Address constants: `ADDR_CTRL`=0, `ADDR_CFG0..2`=1–3, `ADDR_WDOGDIV`=4, `ADDR_HWCFG`=5, `ADDR_WDKICK`=6.
  - FSM state typedef (IDLE, CMD, DATA, DONE).
  - `FRAME_BITS`=16.
- Sub-module `spi_sync`: a `SYNC_STAGES`-deep synchronizer plus edge register, giving level, rise and fall outputs. It is instantiated once per input pin (×3).
- Top level contains the FSM, 4-bit bit counter, RX shift register, TX shift register, address decode and read mux.

## Test plan
- Write 0x01 then 0x0B (address 1, data 0x0B) → `cfgld0` high for exactly 1 clock, `wrtdata`=0x0B; all other strobes stay 0.
- Read 0x80 with `controlrdata`=0xA5 → bits 1,0,1,0,0,1,0,1 observed on `miso` at the host's 9th–16th rising edges; `misoen`=1 throughout the frame.
- Read 0x85 with `hwconfig`=0x30 → host receives 0x30. Change `hwconfig` mid-byte → the returned byte is still 0x30.
- Write 0x06, 0xFF → `wdreset` is a 1-clock pulse and `wrtdata` is unchanged. Write 0x05, 0x12 (address 5) → no strobe at all.
- Write 0x04, 0x3C with `ssn` raised after 12 bits → no `wdogdivld` pulse, `wrtdata` unchanged. The next full frame 0x04, 0x3C → pulse, `wrtdata`=0x3C.
- Assert `reset` for 1 clock after 10 bits of a write to address 0 → no `ctrlld`, `wrtdata`=0x00; `misoen`=0 until `ssn` toggles high then low.
